// File: rtl/arb2w32.sv
// Two-requester round-robin arbiter feeding a single-entry output register over a 32-bit 2:1 mux.
// Optional owner lock enabled by defining ARB2W32_LOCK_EN (adds lock0/lock1 inputs).

module mux2w32 (
    input  logic        sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = (a & {32{~sel}}) | (b & {32{sel}});
endmodule

// Handshake: a word moves downstream on any edge where out_valid=1 and out_ready=1;
// a requester's word is captured on any edge where its gnt is high (req held until then).
module arb2w32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [31:0] data0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        gnt1,
`ifdef ARB2W32_LOCK_EN
    input  logic        lock0,
    input  logic        lock1,
`endif
    output logic        sel,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_src,
    input  logic        out_ready
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state;
    logic        last_src;
    logic [1:0]  req_e;
    logic        pick;
    logic        can_load;
    logic        gnt_any;
    logic [31:0] mux_out;

`ifdef ARB2W32_LOCK_EN
    logic locked;
    logic owner;
    logic lock_sel;

    // While locked, the non-owner is invisible to the arbiter.
    always_comb begin
        req_e = {req1, req0};
        if (locked) req_e = owner ? {req1, 1'b0} : {1'b0, req0};
    end

    assign lock_sel = pick ? lock1 : lock0;
`else
    assign req_e = {req1, req0};
`endif

    // Tie goes to whichever requester was not served last.
    assign pick     = req_e[1] & (~req_e[0] | ~last_src);
    assign can_load = (state == EMPTY) | out_ready;
    assign gnt0     = ~rst & can_load & req_e[0] & ~pick;
    assign gnt1     = ~rst & can_load & req_e[1] & pick;
    assign gnt_any  = gnt0 | gnt1;
    assign sel      = (|req_e) ? pick : last_src;

    assign out_valid = (state == FULL);

    mux2w32 u_mux (
        .sel (sel),
        .a   (data0),
        .b   (data1),
        .y   (mux_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= 32'h0;
            out_src  <= 1'b0;
            last_src <= 1'b1;
`ifdef ARB2W32_LOCK_EN
            locked   <= 1'b0;
            owner    <= 1'b0;
`endif
        end else begin
            if (gnt_any) begin
                out_data <= mux_out;
                out_src  <= pick;
                last_src <= pick;
                state    <= FULL;
            end else if ((state == FULL) && out_ready) begin
                state <= EMPTY;
            end
`ifdef ARB2W32_LOCK_EN
            if (gnt_any) begin
                if (lock_sel) begin
                    locked <= 1'b1;
                    owner  <= pick;
                end else if (locked && (pick == owner)) begin
                    locked <= 1'b0;
                end
            end else if (locked && !(owner ? req1 : req0)) begin
                locked <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_arb2w32.sv
// Directed bench for arb2w32: driver checks grants and queues expected words; a monitor
// pops and compares each word as the consumer accepts it.

module tb_arb2w32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] data0 = 32'h0, data1 = 32'h0;
    logic        gnt0, gnt1, sel, out_valid, out_src;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
`ifdef ARB2W32_LOCK_EN
    logic        lock0 = 1'b0, lock1 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    arb2w32 dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .gnt0      (gnt0),
        .req1      (req1),
        .data1     (data1),
        .gnt1      (gnt1),
`ifdef ARB2W32_LOCK_EN
        .lock0     (lock0),
        .lock1     (lock1),
`endif
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic cycle(input string name, input logic r0, input logic [31:0] d0,
                         input logic r1, input logic [31:0] d1, input logic rdy,
                         input logic eg0, input logic eg1);
        req0 = r0; data0 = d0; req1 = r1; data1 = d1; out_ready = rdy;
        @(negedge clk);
        chk({name, " gnt0"}, {31'b0, gnt0}, {31'b0, eg0});
        chk({name, " gnt1"}, {31'b0, gnt1}, {31'b0, eg1});
        if (eg0) exp_q.push_back({1'b0, d0});
        if (eg1) exp_q.push_back({1'b1, d1});
        @(posedge clk); #1;
    endtask

    // One reset clock with requests still asserted; the in-flight word is discarded.
    task automatic do_reset(input string name, input logic r0, input logic r1);
        rst = 1'b1; req0 = r0; req1 = r1; out_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk({name, " gnt0 in rst"}, {31'b0, gnt0}, 32'd0);
        chk({name, " gnt1 in rst"}, {31'b0, gnt1}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk({name, " out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({name, " out_data"}, out_data, 32'h0);
        chk({name, " out_src"}, {31'b0, out_src}, 32'd0);
    endtask

    // Monitor: compare every word the consumer accepts against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon unexpected word: got %h src %0d expected none", out_data, out_src);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({out_src, out_data} !== e) begin
                    errors++;
                    $display("FAIL mon word: got src %0d data %h expected src %0d data %h",
                             out_src, out_data, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        do_reset("reset", 1'b1, 1'b1);

        // Single request, immediate grant, word visible next cycle.
        cycle("single", 1'b1, 32'h0000_00A5, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("single out_valid", {31'b0, out_valid}, 32'd1);
        chk("single out_data", out_data, 32'h0000_00A5);
        cycle("drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("idle sel holds last", {31'b0, sel}, 32'd0);
        chk("idle out_valid", {31'b0, out_valid}, 32'd0);

        // Serve requester 1 so the following tie starts with requester 0.
        cycle("only1", 1'b0, 32'h0, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 1'b1);

        // Continuous tie alternates.
        cycle("rr0", 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
        cycle("rr1", 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b1);
        cycle("rr2", 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
        cycle("rr3", 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b1);

        // Back-pressure: no grant while full and stalled, held word stable.
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b0, 32'h0, 1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0);
            chk("stall out_data", out_data, 32'h2222_2222);
            chk("stall out_src", {31'b0, out_src}, 32'd1);
        end
        cycle("release", 1'b0, 32'h0, 1'b1, 32'h4444_4444, 1'b1, 1'b0, 1'b1);
        chk("release out_data", out_data, 32'h4444_4444);

        // Drain and load on the same edge: no bubble.
        cycle("swap", 1'b1, 32'h5555_5555, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("swap out_valid", {31'b0, out_valid}, 32'd1);
        chk("swap out_data", out_data, 32'h5555_5555);
        chk("swap out_src", {31'b0, out_src}, 32'd0);

        // Reset with a grant pending; tie afterwards goes to requester 0.
        cycle("pending", 1'b1, 32'h6666_6666, 1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
        do_reset("midrst", 1'b1, 1'b1);
        cycle("post rst tie", 1'b1, 32'h6666_6666, 1'b1, 32'h7777_7777, 1'b1, 1'b1, 1'b0);
        cycle("post rst 1", 1'b0, 32'h0, 1'b1, 32'h7777_7777, 1'b1, 1'b0, 1'b1);

`ifdef ARB2W32_LOCK_EN
        // Requester 0 holds the lock for three grants, keeps the fourth, then releases.
        lock0 = 1'b1;
        cycle("lock a", 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
        cycle("lock b", 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
        cycle("lock c", 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
        lock0 = 1'b0;
        cycle("lock d", 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
        cycle("lock e", 1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 1'b1);
`endif

        cycle("final drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("queue empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
